// File: rtl/result_packer_writer.sv
// ----------------------------------------------------------------------------
// result_packer_writer
//
// Downstream stage of the convolution datapath. Accepts 8-bit results from
// the accumulator over a valid/ready handshake, packs four of them into one
// 32-bit word (first result in the least significant lane), and writes each
// word to sequential addresses of the result region. A partially filled
// final word is written with its unfilled lanes zero. done is raised once
// the programmed number of results has been written and is held until the
// next accepted start.
//
// Ports
//   clk_i          in   1       rising-edge clock
//   rst_i          in   1       asynchronous reset, active-high
//   start_i        in   1       one-cycle job start (honoured in IDLE/DONE)
//   base_addr_i    in   ADDR_W  first word address, latched on start
//   num_results_i  in   8       result count of the job, latched on start
//   res_valid_i    in   1       res_data_i holds a result
//   res_data_i     in   DATA_W  result byte
//   res_ready_o    out  1       a result can be accepted this cycle
//   mem_wr_en_o    out  1       one-cycle memory write strobe
//   mem_addr_o     out  ADDR_W  write address (held between writes)
//   mem_wr_data_o  out  WORD_W  packed write word (held between writes)
//   done_o         out  1       job complete, level
//
// State    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | no job since reset; waiting for start
// COLLECT  | accepting result bytes into the pack register
// WRITE    | single cycle with the packed word on the memory port
// DONE     | job finished, done held; start begins a new job
// ----------------------------------------------------------------------------
module result_packer_writer #(
    parameter int DATA_W = 8,
    parameter int WORD_W = 32,
    parameter int ADDR_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    input  logic [7:0]        num_results_i,
    input  logic              res_valid_i,
    input  logic [DATA_W-1:0] res_data_i,
    output logic              res_ready_o,
    output logic              mem_wr_en_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [WORD_W-1:0] mem_wr_data_o,
    output logic              done_o
);

    localparam int LANES = WORD_W / DATA_W;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_COLLECT = 2'd1;
    localparam logic [1:0] S_WRITE   = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;

    logic [1:0]        state_q,     state_d;
    logic [WORD_W-1:0] pack_q,      pack_d;
    logic [1:0]        lane_cnt_q,  lane_cnt_d;
    logic [7:0]        recv_cnt_q,  recv_cnt_d;
    logic [7:0]        num_q,       num_d;
    logic [ADDR_W-1:0] word_addr_q, word_addr_d;

    logic              res_ready_q, res_ready_d;
    logic              mem_wr_en_q, mem_wr_en_d;
    logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
    logic [WORD_W-1:0] mem_data_q,  mem_data_d;
    logic              done_q,      done_d;

    logic              accept;
    logic              word_full;
    logic              last_byte;
    logic [WORD_W-1:0] pack_merged;

    // res_ready_q already reflects the COLLECT state for the current cycle,
    // so it alone qualifies the handshake.
    assign accept = res_valid_i && res_ready_q;

    always_comb begin
        pack_merged = pack_q;
        for (int k = 0; k < LANES; k++) begin
            if (lane_cnt_q == 2'(k)) begin
                pack_merged[k*DATA_W +: DATA_W] = res_data_i;
            end
        end
    end

    assign word_full = (lane_cnt_q == 2'(LANES - 1));
    assign last_byte = ((recv_cnt_q + 8'd1) == num_q);

    // Next-state logic. The registered outputs are derived from the next
    // state below so that they line up with the state they describe.
    always_comb begin
        state_d     = state_q;
        pack_d      = pack_q;
        lane_cnt_d  = lane_cnt_q;
        recv_cnt_d  = recv_cnt_q;
        num_d       = num_q;
        word_addr_d = word_addr_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_i) begin
                    word_addr_d = base_addr_i;
                    num_d       = num_results_i;
                    recv_cnt_d  = 8'd0;
                    lane_cnt_d  = 2'd0;
                    pack_d      = '0;
                    state_d     = (num_results_i == 8'd0) ? S_DONE : S_COLLECT;
                end
            end
            S_COLLECT: begin
                if (accept) begin
                    pack_d     = pack_merged;
                    lane_cnt_d = lane_cnt_q + 2'd1;
                    recv_cnt_d = recv_cnt_q + 8'd1;
                    if (word_full || last_byte) begin
                        state_d = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                word_addr_d = word_addr_q + 1'b1;
                pack_d      = '0;
                lane_cnt_d  = 2'd0;
                state_d     = (recv_cnt_q == num_q) ? S_DONE : S_COLLECT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output staging: the write port is loaded on the edge that enters
    // WRITE, using the pack value that includes the byte accepted on that
    // same edge. Address and data hold outside WRITE.
    always_comb begin
        res_ready_d = (state_d == S_COLLECT);
        done_d      = (state_d == S_DONE);
        mem_wr_en_d = (state_d == S_WRITE);
        mem_addr_d  = mem_addr_q;
        mem_data_d  = mem_data_q;
        if (state_d == S_WRITE) begin
            mem_addr_d = word_addr_q;
            mem_data_d = pack_d;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            pack_q      <= '0;
            lane_cnt_q  <= 2'd0;
            recv_cnt_q  <= 8'd0;
            num_q       <= 8'd0;
            word_addr_q <= '0;
            res_ready_q <= 1'b0;
            mem_wr_en_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_data_q  <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pack_q      <= pack_d;
            lane_cnt_q  <= lane_cnt_d;
            recv_cnt_q  <= recv_cnt_d;
            num_q       <= num_d;
            word_addr_q <= word_addr_d;
            res_ready_q <= res_ready_d;
            mem_wr_en_q <= mem_wr_en_d;
            mem_addr_q  <= mem_addr_d;
            mem_data_q  <= mem_data_d;
            done_q      <= done_d;
        end
    end

    assign res_ready_o   = res_ready_q;
    assign mem_wr_en_o   = mem_wr_en_q;
    assign mem_addr_o    = mem_addr_q;
    assign mem_wr_data_o = mem_data_q;
    assign done_o        = done_q;

endmodule

// File: tb/tb_result_packer_writer.sv
module tb_result_packer_writer;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic [7:0]  base_addr_i;
    logic [7:0]  num_results_i;
    logic        res_valid_i;
    logic [7:0]  res_data_i;
    logic        res_ready_o;
    logic        mem_wr_en_o;
    logic [7:0]  mem_addr_o;
    logic [31:0] mem_wr_data_o;
    logic        done_o;

    int n_cmp = 0;
    int n_err = 0;

    logic [39:0] wq[$];

    result_packer_writer #(.DATA_W(8), .WORD_W(32), .ADDR_W(8)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .start_i       (start_i),
        .base_addr_i   (base_addr_i),
        .num_results_i (num_results_i),
        .res_valid_i   (res_valid_i),
        .res_data_i    (res_data_i),
        .res_ready_o   (res_ready_o),
        .mem_wr_en_o   (mem_wr_en_o),
        .mem_addr_o    (mem_addr_o),
        .mem_wr_data_o (mem_wr_data_o),
        .done_o        (done_o)
    );

    always #5 clk_i = ~clk_i;

    always @(negedge clk_i) begin
        if (mem_wr_en_o) wq.push_back({mem_addr_o, mem_wr_data_o});
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_start(input logic [7:0] base, input logic [7:0] num);
        start_i       = 1'b1;
        base_addr_i   = base;
        num_results_i = num;
        tick();
        start_i = 1'b0;
    endtask

    task automatic push(input logic [7:0] b, input int gap);
        logic ok;
        res_valid_i = 1'b0;
        repeat (gap) tick();
        res_valid_i = 1'b1;
        res_data_i  = b;
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            ok = res_ready_o;
            tick();
        end
        chk("push_accept", 64'(ok), 64'd1);
    endtask

    task automatic pulse_reset();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        tick();
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_ready"}, 64'(res_ready_o), 64'd0);
        chk({tag, "_wren"},  64'(mem_wr_en_o), 64'd0);
        chk({tag, "_addr"},  64'(mem_addr_o), 64'd0);
        chk({tag, "_data"},  64'(mem_wr_data_o), 64'd0);
        chk({tag, "_done"},  64'(done_o), 64'd0);
    endtask

    task automatic run_job1();
        wq.delete();
        do_start(8'h10, 8'd8);
        chk("t1_ready_after_start", 64'(res_ready_o), 64'd1);
        chk("t1_done_after_start", 64'(done_o), 64'd0);
        for (int i = 1; i <= 4; i++) push(8'(i), 0);
        chk("t1_w0_en", 64'(mem_wr_en_o), 64'd1);
        chk("t1_w0_addr", 64'(mem_addr_o), 64'h10);
        chk("t1_w0_data", 64'(mem_wr_data_o), 64'h04030201);
        chk("t1_ready_in_write", 64'(res_ready_o), 64'd0);
        for (int i = 5; i <= 8; i++) push(8'(i), 0);
        res_valid_i = 1'b0;
        chk("t1_w1_en", 64'(mem_wr_en_o), 64'd1);
        chk("t1_w1_addr", 64'(mem_addr_o), 64'h11);
        chk("t1_w1_data", 64'(mem_wr_data_o), 64'h08070605);
        chk("t1_done_early", 64'(done_o), 64'd0);
        tick();
        chk("t1_done", 64'(done_o), 64'd1);
        chk("t1_wren_off", 64'(mem_wr_en_o), 64'd0);
        chk("t1_addr_hold", 64'(mem_addr_o), 64'h11);
        chk("t1_data_hold", 64'(mem_wr_data_o), 64'h08070605);
        tick();
        chk("t1_nwrites", 64'(wq.size()), 64'd2);
        if (wq.size() == 2) begin
            chk("t1_q0", 64'(wq[0]), 64'h10_04030201);
            chk("t1_q1", 64'(wq[1]), 64'h11_08070605);
        end
    endtask

    initial begin
        rst_i = 1'b1;
        start_i = 1'b0;
        base_addr_i = 8'h00;
        num_results_i = 8'd0;
        res_valid_i = 1'b0;
        res_data_i = 8'h00;
        tick();
        tick();
        check_idle_outputs("reset");
        rst_i = 1'b0;
        tick();
        check_idle_outputs("post_reset");

        // Test 1: two full words, back-to-back bytes
        run_job1();

        // Test 2: partial final word (restart from DONE)
        wq.delete();
        do_start(8'h40, 8'd5);
        chk("t2_done_drop", 64'(done_o), 64'd0);
        for (int i = 0; i < 5; i++) push(8'h0A + 8'(i), 0);
        res_valid_i = 1'b0;
        chk("t2_w1_data", 64'(mem_wr_data_o), 64'h0000000E);
        tick();
        chk("t2_done", 64'(done_o), 64'd1);
        repeat (3) tick();
        chk("t2_done_held", 64'(done_o), 64'd1);
        chk("t2_nwrites", 64'(wq.size()), 64'd2);
        if (wq.size() == 2) begin
            chk("t2_q0", 64'(wq[0]), 64'h40_0D0C0B0A);
            chk("t2_q1", 64'(wq[1]), 64'h41_0000000E);
        end

        // Test 3: zero-length job from IDLE, then a clean restart
        pulse_reset();
        wq.delete();
        chk("t3_done_before", 64'(done_o), 64'd0);
        do_start(8'h55, 8'd0);
        chk("t3_done", 64'(done_o), 64'd1);
        chk("t3_ready", 64'(res_ready_o), 64'd0);
        chk("t3_wren", 64'(mem_wr_en_o), 64'd0);
        repeat (3) tick();
        chk("t3_nwrites_zero", 64'(wq.size()), 64'd0);
        do_start(8'h20, 8'd4);
        chk("t3_done_drop", 64'(done_o), 64'd0);
        chk("t3_ready_restart", 64'(res_ready_o), 64'd1);
        for (int i = 0; i < 4; i++) push(8'hA1 + 8'(i), 0);
        res_valid_i = 1'b0;
        tick();
        chk("t3_done2", 64'(done_o), 64'd1);
        chk("t3_nwrites", 64'(wq.size()), 64'd1);
        if (wq.size() == 1) chk("t3_q0", 64'(wq[0]), 64'h20_A4A3A2A1);

        // Test 4: address wrap
        wq.delete();
        do_start(8'hFF, 8'd8);
        for (int i = 0; i < 8; i++) push(8'h31 + 8'(i), 0);
        res_valid_i = 1'b0;
        tick();
        chk("t4_done", 64'(done_o), 64'd1);
        chk("t4_nwrites", 64'(wq.size()), 64'd2);
        if (wq.size() == 2) begin
            chk("t4_q0", 64'(wq[0]), 64'hFF_34333231);
            chk("t4_q1", 64'(wq[1]), 64'h00_38373635);
        end

        // Test 5: valid gaps, valid held through WRITE, stray start mid-job
        wq.delete();
        do_start(8'h80, 8'd12);
        for (int i = 0; i < 12; i++) begin
            if (i == 6) begin
                res_valid_i   = 1'b0;
                start_i       = 1'b1;
                base_addr_i   = 8'h00;
                num_results_i = 8'd1;
                tick();
                start_i = 1'b0;
            end
            push(8'h21 + 8'(i), (i == 4 || i == 8) ? 0 : int'($urandom_range(0, 3)));
        end
        res_valid_i = 1'b0;
        tick();
        chk("t5_done", 64'(done_o), 64'd1);
        chk("t5_nwrites", 64'(wq.size()), 64'd3);
        if (wq.size() == 3) begin
            chk("t5_q0", 64'(wq[0]), 64'h80_24232221);
            chk("t5_q1", 64'(wq[1]), 64'h81_28272625);
            chk("t5_q2", 64'(wq[2]), 64'h82_2C2B2A29);
        end

        // Test 6: reset in the middle of a job
        wq.delete();
        do_start(8'h10, 8'd8);
        push(8'h01, 0);
        push(8'h02, 0);
        res_valid_i = 1'b0;
        chk("t6_ready_before_rst", 64'(res_ready_o), 64'd1);
        rst_i = 1'b1;
        #1;
        check_idle_outputs("t6_async");
        tick();
        rst_i = 1'b0;
        repeat (3) tick();
        chk("t6_no_write", 64'(wq.size()), 64'd0);
        check_idle_outputs("t6_after");
        run_job1();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
